pattern_serializer: RTL and testbench
=====================================

PATTERN_SERIALIZER -- requirements
Module: pattern_serializer

Interface
REQ-001 Parameter RATE_DIV, default 1, clock cycles per serial bit (legal range 1..255).
REQ-002 Clock  input  1  rising-edge system clock.
REQ-003 Resetn  input  1  reset; synchronous, active-low.
REQ-004 Load  input  1  capture Pattern and Len; acted on in IDLE only.
REQ-005 Pattern  input  16  bit pattern to transmit, MSB-first starting at bit Len.
REQ-006 Len  input  4  pattern length minus one (0 = 1 bit, 15 = 16 bits).
REQ-007 Start  input  1  begin transmission; acted on in IDLE only.
REQ-008 Repeat  input  1  sampled at end of each pass; high = restart the pass.
REQ-009 Abort  input  1  terminate transmission immediately.
REQ-010 w  output  1  serial bit to the downstream sequence detector.
REQ-011 BitValid  output  1  one-cycle strobe marking the last cycle of each bit period.
REQ-012 Busy  output  1  high while transmitting.
REQ-013 Done  output  1  one-cycle pulse on normal completion.
REQ-014 BitIdx  output  4  index of the bit currently driven on w.

Function
REQ-015 The block SHALL implement states IDLE, SEND and DONE.
REQ-016 In IDLE, Load SHALL update pat_r <= Pattern and len_r <= Len at the clock edge.
REQ-017 Load outside IDLE SHALL be ignored.
REQ-018 Start in IDLE SHALL move to SEND, with idx <= Len when Load is also high in the same cycle, else idx <= len_r.
REQ-019 With Start and Load together, the first pass SHALL use the new Pattern and Len.
REQ-020 Start outside IDLE SHALL be ignored.
REQ-021 In SEND: w = pat_r[idx], BitIdx = idx, Busy = 1.
REQ-022 In SEND, divider cnt SHALL count 0..RATE_DIV-1; BitValid = (cnt == RATE_DIV-1), so w is held RATE_DIV cycles per bit.
REQ-023 At end of bit period with idx > 0: idx <= idx-1 and cnt <= 0.
REQ-024 At end of bit period with idx = 0 and Repeat = 1: idx <= len_r, remain in SEND, no gap cycle.
REQ-025 At end of bit period with idx = 0 and Repeat = 0: go to DONE.
REQ-026 DONE SHALL last one cycle with Done = 1, w = 0, Busy = 0, then go to IDLE.
REQ-027 In IDLE and DONE: w = 0 and BitValid = 0; Done = 0 outside DONE.
REQ-028 Abort high in SEND SHALL go to IDLE next edge with no Done pulse; Abort has priority over Repeat and end-of-pass.
REQ-029 Abort in IDLE or DONE SHALL have no effect.
REQ-030 Latency: Start sampled at edge k gives first bit on w in cycle k+1 and first BitValid in cycle k+RATE_DIV.
REQ-031 RATE_DIV = 1 SHALL produce BitValid every SEND cycle.
REQ-032 The divider SHALL be wide enough for RATE_DIV-1 without wrap.
REQ-033 An illegal state encoding SHALL recover to IDLE on the next edge.
REQ-034 All outputs SHALL be functions of registered state only (Moore), so w can feed the detector input directly.

Reset
REQ-035 Resetn low at a clock edge SHALL set state = IDLE, pat_r = 0, len_r = 0, idx = 0, cnt = 0.
REQ-036 During and after reset: w = 0, BitValid = 0, Busy = 0, Done = 0, BitIdx = 0.
REQ-037 Reset SHALL override Load, Start and Abort.
REQ-038 Reset mid-SEND SHALL abort with no Done pulse and SHALL clear the loaded pattern.

Verification
REQ-039 RATE_DIV=1: Load Pattern=16'h000D, Len=3, then Start -> w = 1,1,0,1 on 4 consecutive cycles; BitValid high all 4; BitIdx = 3,2,1,0; Done pulse on cycle 5; Busy low from cycle 5.
REQ-040 RATE_DIV=4, same stimulus -> each bit held 4 cycles; BitValid only on the 4th cycle of each bit; Done on cycle 17 after Start.
REQ-041 Repeat=1, Pattern=16'h000F, Len=3 -> w continuously 1 with no Done; Repeat dropped mid-pass -> current pass completes, then one Done pulse.
REQ-042 Abort asserted while BitIdx=2 -> next cycle w=0, Busy=0, no Done; a subsequent Start resends the same loaded pattern.
REQ-043 Resetn low mid-SEND, then Start with no Load -> one bit w=0 (len_r=0, pat_r=0) followed by a Done pulse.
REQ-044 Load 16'hFFFF while Busy -> ignored (original pattern continues); Start+Load same cycle in IDLE with 16'h0005, Len=2 -> w = 1,0,1.

Source files
------------

// File: rtl/pattern_serializer.sv
// Serializes a loaded bit pattern MSB-first onto w, one bit per RATE_DIV clocks.
// Moore outputs feed a downstream sequence detector directly.
module pattern_serializer #(
   parameter int unsigned RATE_DIV = 1
) (
   input  logic        Clock,
   input  logic        Resetn,
   input  logic        Load,
   input  logic [15:0] Pattern,
   input  logic [3:0]  Len,
   input  logic        Start,
   input  logic        Repeat,
   input  logic        Abort,
   output logic        w,
   output logic        BitValid,
   output logic        Busy,
   output logic        Done,
   output logic [3:0]  BitIdx
);

   // 8 bits cover the largest legal divide of 255 without wrap
   localparam logic [7:0] CNT_MAX = 8'(RATE_DIV - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_SEND = 2'b01,
      ST_DONE = 2'b10
   } state_t;

   state_t      state_q, state_d;
   logic [15:0] pat_q, pat_d;
   logic [3:0]  len_q, len_d;
   logic [3:0]  idx_q, idx_d;
   logic [7:0]  cnt_q, cnt_d;

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge Clock) begin
      if (!Resetn) begin
         state_q <= ST_IDLE;
         pat_q   <= 16'h0000;
         len_q   <= 4'd0;
         idx_q   <= 4'd0;
         cnt_q   <= 8'd0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state and datapath update
   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      len_d   = len_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_IDLE: begin
            if (Load) begin
               pat_d = Pattern;
               len_d = Len;
            end else begin
               pat_d = pat_q;
               len_d = len_q;
            end
            // A simultaneous Load must launch the freshly supplied length
            if (Start) begin
               state_d = ST_SEND;
               cnt_d   = 8'd0;
               idx_d   = Load ? Len : len_q;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SEND: begin
            if (Abort) begin
               state_d = ST_IDLE;
            end else if (cnt_q == CNT_MAX) begin
               cnt_d = 8'd0;
               if (idx_q != 4'd0) begin
                  idx_d = idx_q - 4'd1;
               end else if (Repeat) begin
                  idx_d = len_q;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               cnt_d = cnt_q + 8'd1;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode from registered state only
   always_comb begin
      w        = 1'b0;
      BitValid = 1'b0;
      Busy     = 1'b0;
      Done     = 1'b0;
      BitIdx   = 4'd0;
      case (state_q)
         ST_SEND: begin
            w        = pat_q[idx_q];
            BitValid = (cnt_q == CNT_MAX);
            Busy     = 1'b1;
            BitIdx   = idx_q;
         end
         ST_DONE: begin
            Done = 1'b1;
         end
         default: begin
            Done = 1'b0;
         end
      endcase
   end

endmodule

// File: tb/tb_pattern_serializer.sv
// Directed bench for pattern_serializer at RATE_DIV=1 (dut1) and RATE_DIV=4 (dut4).
module tb_pattern_serializer;

   logic        Clock = 1'b0;
   logic        Resetn, Load, Start, Repeat, Abort, Load4, Start4;
   logic [15:0] Pattern;
   logic [3:0]  Len;
   logic        w1, bv1, busy1, done1;
   logic [3:0]  idx1;
   logic        w4, bv4, busy4, done4;
   logic [3:0]  idx4;
   int          n_checks = 0;
   int          n_fail   = 0;

   always #5 Clock = ~Clock;

   pattern_serializer #(.RATE_DIV(1)) dut1 (
      .Clock(Clock), .Resetn(Resetn), .Load(Load), .Pattern(Pattern), .Len(Len),
      .Start(Start), .Repeat(Repeat), .Abort(Abort),
      .w(w1), .BitValid(bv1), .Busy(busy1), .Done(done1), .BitIdx(idx1));

   pattern_serializer #(.RATE_DIV(4)) dut4 (
      .Clock(Clock), .Resetn(Resetn), .Load(Load4), .Pattern(Pattern), .Len(Len),
      .Start(Start4), .Repeat(Repeat), .Abort(Abort),
      .w(w4), .BitValid(bv4), .Busy(busy4), .Done(done4), .BitIdx(idx4));

   task automatic tick();
      @(posedge Clock);
      #1;
   endtask

   task automatic test_reset();
      Resetn = 1'b0; Load = 1'b0; Start = 1'b0; Repeat = 1'b0; Abort = 1'b0;
      Load4 = 1'b0; Start4 = 1'b0; Pattern = 16'h0000; Len = 4'd0;
      tick(); tick();
      n_checks++;
      if ({w1, bv1, busy1, done1, idx1} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_dut1: got %b want 00000000", {w1, bv1, busy1, done1, idx1});
      end
      n_checks++;
      if ({w4, bv4, busy4, done4, idx4} !== 8'h00) begin
         n_fail++;
         $display("FAIL reset_dut4: got %b want 00000000", {w4, bv4, busy4, done4, idx4});
      end
      Resetn = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      logic [3:0] exp_w;
      exp_w = 4'b1011;   // bits sent in order for 16'h000D, Len=3: 1,1,0,1
      Pattern = 16'h000D; Len = 4'd3; Load = 1'b1;
      tick();
      Load = 1'b0; Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if ({w1, bv1, busy1, idx1} !== {exp_w[i], 1'b1, 1'b1, 4'(3 - i)}) begin
            n_fail++;
            $display("FAIL basic_bit%0d: w/bv/busy/idx got %b want %b", i,
                     {w1, bv1, busy1, idx1}, {exp_w[i], 1'b1, 1'b1, 4'(3 - i)});
         end
         tick();
      end
      n_checks++;
      if ({done1, busy1, w1} !== 3'b100) begin
         n_fail++;
         $display("FAIL basic_done: done/busy/w got %b want 100", {done1, busy1, w1});
      end
      tick();
      n_checks++;
      if (done1 !== 1'b0) begin
         n_fail++;
         $display("FAIL basic_done_len: done got %b want 0", done1);
      end
   endtask

   task automatic test_rate4();
      logic [3:0] exp_w;
      logic       ebv;
      exp_w = 4'b1011;
      Pattern = 16'h000D; Len = 4'd3; Load4 = 1'b1;
      tick();
      Load4 = 1'b0; Start4 = 1'b1;
      tick();
      Start4 = 1'b0;
      for (int c = 0; c < 16; c++) begin
         ebv = ((c % 4) == 3);
         n_checks++;
         if ({w4, bv4, busy4, done4, idx4} !== {exp_w[c / 4], ebv, 1'b1, 1'b0, 4'(3 - c / 4)}) begin
            n_fail++;
            $display("FAIL rate4_cycle%0d: w/bv/busy/done/idx got %b want %b", c + 1,
                     {w4, bv4, busy4, done4, idx4}, {exp_w[c / 4], ebv, 1'b1, 1'b0, 4'(3 - c / 4)});
         end
         tick();
      end
      n_checks++;
      if ({done4, busy4} !== 2'b10) begin
         n_fail++;
         $display("FAIL rate4_done17: done/busy got %b want 10", {done4, busy4});
      end
      tick();
   endtask

   task automatic test_repeat();
      Pattern = 16'h000F; Len = 4'd3; Load = 1'b1;
      tick();
      Load = 1'b0; Start = 1'b1; Repeat = 1'b1;
      tick();
      Start = 1'b0;
      for (int c = 1; c <= 16; c++) begin
         n_checks++;
         if ({w1, busy1, done1} !== 3'b110) begin
            n_fail++;
            $display("FAIL repeat_cycle%0d: w/busy/done got %b want 110", c, {w1, busy1, done1});
         end
         if (c == 14) Repeat = 1'b0;
         tick();
      end
      n_checks++;
      if ({done1, busy1} !== 2'b10) begin
         n_fail++;
         $display("FAIL repeat_done: done/busy got %b want 10", {done1, busy1});
      end
      tick();
   endtask

   task automatic test_abort();
      logic [3:0] exp_w;
      exp_w = 4'b1011;
      Pattern = 16'h000D; Len = 4'd3; Load = 1'b1;
      tick();
      Load = 1'b0; Start = 1'b1;
      tick();
      Start = 1'b0;
      tick();
      n_checks++;
      if (idx1 !== 4'd2) begin
         n_fail++;
         $display("FAIL abort_idx: BitIdx got %0d want 2", idx1);
      end
      Abort = 1'b1; Repeat = 1'b1;
      tick();
      Abort = 1'b0; Repeat = 1'b0;
      n_checks++;
      if ({w1, busy1, done1} !== 3'b000) begin
         n_fail++;
         $display("FAIL abort_stop: w/busy/done got %b want 000", {w1, busy1, done1});
      end
      tick();
      n_checks++;
      if ({busy1, done1} !== 2'b00) begin
         n_fail++;
         $display("FAIL abort_nodone: busy/done got %b want 00", {busy1, done1});
      end
      Start = 1'b1;
      tick();
      Start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         n_checks++;
         if ({w1, idx1} !== {exp_w[i], 4'(3 - i)}) begin
            n_fail++;
            $display("FAIL abort_resend%0d: w/idx got %b want %b", i, {w1, idx1}, {exp_w[i], 4'(3 - i)});
         end
         tick();
      end
      n_checks++;
      if (done1 !== 1'b1) begin
         n_fail++;
         $display("FAIL abort_resend_done: done got %b want 1", done1);
      end
      tick();
   endtask

   task automatic test_reset_mid();
      Pattern = 16'h000D; Len = 4'd3; Load = 1'b1;
      tick();
      Load = 1'b0; Start = 1'b1;
      tick();
      Start = 1'b0;
      tick();
      // reset must win over a simultaneous Load+Start
      Resetn = 1'b0; Load = 1'b1; Start = 1'b1; Pattern = 16'hFFFF; Len = 4'd7;
      tick();
      n_checks++;
      if ({w1, bv1, busy1, done1, idx1} !== 8'h00) begin
         n_fail++;
         $display("FAIL resetmid_outputs: got %b want 00000000", {w1, bv1, busy1, done1, idx1});
      end
      Resetn = 1'b1; Load = 1'b0; Start = 1'b0;
      tick();
      n_checks++;
      if ({busy1, done1} !== 2'b00) begin
         n_fail++;
         $display("FAIL resetmid_after: busy/done got %b want 00", {busy1, done1});
      end
      Start = 1'b1;
      tick();
      Start = 1'b0;
      n_checks++;
      if ({w1, bv1, busy1, idx1} !== 7'b0110000) begin
         n_fail++;
         $display("FAIL resetmid_bit: w/bv/busy/idx got %b want 0110000", {w1, bv1, busy1, idx1});
      end
      tick();
      n_checks++;
      if ({done1, busy1} !== 2'b10) begin
         n_fail++;
         $display("FAIL resetmid_done: done/busy got %b want 10", {done1, busy1});
      end
      tick();
   endtask

   task automatic test_load_busy();
      logic [2:0] exp_w;
      Pattern = 16'h000D; Len = 4'd3; Load = 1'b1;
      tick();
      Load = 1'b0; Start = 1'b1;
      tick();
      Start = 1'b0; Pattern = 16'hFFFF; Len = 4'd15; Load = 1'b1;
      tick();
      Load = 1'b0;
      exp_w = 3'b101;   // remaining bits of 16'h000D: 1,0,1
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({w1, idx1} !== {exp_w[i], 4'(2 - i)}) begin
            n_fail++;
            $display("FAIL loadbusy_bit%0d: w/idx got %b want %b", i, {w1, idx1}, {exp_w[i], 4'(2 - i)});
         end
         tick();
      end
      n_checks++;
      if (done1 !== 1'b1) begin
         n_fail++;
         $display("FAIL loadbusy_done: done got %b want 1", done1);
      end
      tick();
      Pattern = 16'h0005; Len = 4'd2; Load = 1'b1; Start = 1'b1;
      tick();
      Load = 1'b0; Start = 1'b0;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({w1, busy1, idx1} !== {exp_w[i], 1'b1, 4'(2 - i)}) begin
            n_fail++;
            $display("FAIL startload_bit%0d: w/busy/idx got %b want %b", i,
                     {w1, busy1, idx1}, {exp_w[i], 1'b1, 4'(2 - i)});
         end
         tick();
      end
      n_checks++;
      if ({done1, busy1} !== 2'b10) begin
         n_fail++;
         $display("FAIL startload_done: done/busy got %b want 10", {done1, busy1});
      end
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_rate4();
      test_repeat();
      test_abort();
      test_reset_mid();
      test_load_busy();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
